// File: rtl/backor_pkg.sv
// backor_pkg: shared widths, OR-window tables and the window reducer.
// Build option: define BACKOR_WIDE_EN to widen every window by one bit on each side.
package backor_pkg;

    localparam int BACK_W = 28;
    localparam int RET_W  = 18;

    typedef logic [BACK_W-1:0] backor_t;
    typedef logic [RET_W-1:0]  ret_t;

    // Narrow window bounds, bin k covers back[LO_N[k] .. HI_N[k]]
    localparam int LO_N [0:RET_W-1] = '{1, 2, 3, 5, 6, 7, 9, 10, 12, 13, 14, 16, 17, 18, 20, 21, 22, 24};
    localparam int HI_N [0:RET_W-1] = '{3, 5, 6, 7, 9, 10, 11, 13, 14, 15, 17, 18, 20, 21, 22, 24, 25, 26};

`ifdef BACKOR_WIDE_EN
    localparam int WIN_ADJ = 1;
`else
    localparam int WIN_ADJ = 0;
`endif

    // Reduce a back-hit vector to the overlapping OR bins.
    function automatic ret_t backor_reduce(input backor_t back);
        ret_t r;
        r = '0;
        for (int k = 0; k < RET_W; k++) begin
            for (int j = 0; j < BACK_W; j++) begin
                if ((j >= LO_N[k] - WIN_ADJ) && (j <= HI_N[k] + WIN_ADJ)) begin
                    r[k] = r[k] | back[j];
                end else begin
                    r[k] = r[k];
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/backor_scheduler_if.sv
// backor_scheduler_if: requester-side and result-side handshake bundle.
interface backor_scheduler_if
    import backor_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int TAGW = 3
);

    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ*BACK_W-1:0] req_back;
    logic                   out_valid;
    logic                   out_ready;
    ret_t                   out_ret;
    logic                   out_any;
    logic [TAGW-1:0]        out_tag;

    // Requesters plus downstream consumer
    modport master (
        output req_valid, req_back, out_ready,
        input  req_ready, out_valid, out_ret, out_any, out_tag
    );

    // The scheduler itself
    modport slave (
        input  req_valid, req_back, out_ready,
        output req_ready, out_valid, out_ret, out_any, out_tag
    );

endinterface

// File: rtl/backor_rr_arb.sv
// backor_rr_arb: round-robin arbiter. The grant is the first valid requester
// at or after rr_ptr (wrapping); the pointer moves past a winner only when the
// grant is actually taken (en high).
module backor_rr_arb #(
    parameter int NREQ = 4,
    parameter int TAGW = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    input  logic            en,
    output logic [NREQ-1:0] gnt,
    output logic [TAGW-1:0] gnt_idx,
    output logic            gnt_any
);

    logic [TAGW-1:0] rr_ptr_r;
    logic [TAGW-1:0] idx_s;
    logic            found_s;
    int              dist_s;
    int              best_s;

    // Pick the valid requester with the smallest rotational distance from rr_ptr
    always_comb begin
        found_s = 1'b0;
        idx_s   = '0;
        dist_s  = 0;
        best_s  = NREQ;
        for (int i = 0; i < NREQ; i++) begin
            dist_s = i - int'(rr_ptr_r);
            if (dist_s < 0) begin
                dist_s = dist_s + NREQ;
            end else begin
                dist_s = dist_s;
            end
            if (req[i] && (dist_s < best_s)) begin
                best_s  = dist_s;
                idx_s   = TAGW'(i);
                found_s = 1'b1;
            end else begin
                best_s  = best_s;
            end
        end
    end

    // One-hot grant, only asserted when the consumer can take it
    always_comb begin
        gnt = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (en && found_s && (idx_s == TAGW'(i))) begin
                gnt[i] = 1'b1;
            end else begin
                gnt[i] = 1'b0;
            end
        end
    end

    assign gnt_idx = idx_s;
    assign gnt_any = en & found_s;

    // Advance the rotation pointer just past the requester that was served
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_r <= '0;
        end else if (en && found_s) begin
            if (idx_s == TAGW'(NREQ - 1)) begin
                rr_ptr_r <= '0;
            end else begin
                rr_ptr_r <= idx_s + TAGW'(1);
            end
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end

endmodule

// File: rtl/backor_scheduler.sv
// backor_scheduler: shares one OR-window reducer among NREQ requesters through
// a two-stage pipeline (S1 capture, S2 reduce+register) with tagged results.
// Build option: BACKOR_WIDE_EN selects the widened windows (see backor_pkg).
module backor_scheduler
    import backor_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int TAGW = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    backor_scheduler_if.slave  bus,
    output logic [15:0]        acc_count
);

    logic            s2_load_s;
    logic            s1_load_s;
    logic [NREQ-1:0] gnt_s;
    logic [TAGW-1:0] gnt_idx_s;
    logic            accept_s;
    backor_t         sel_back_s;
    ret_t            red_s;

    logic            s1_v_r;
    backor_t         s1_back_r;
    logic [TAGW-1:0] s1_tag_r;
    logic            out_valid_r;
    ret_t            out_ret_r;
    logic            out_any_r;
    logic [TAGW-1:0] out_tag_r;
    logic [15:0]     acc_count_r;

    // S2 takes data when it is empty or its result leaves this cycle; S1 follows.
    assign s2_load_s = ~out_valid_r | bus.out_ready;
    assign s1_load_s = ~s1_v_r | s2_load_s;

    backor_rr_arb #(
        .NREQ (NREQ),
        .TAGW (TAGW)
    ) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (bus.req_valid),
        .en      (s1_load_s),
        .gnt     (gnt_s),
        .gnt_idx (gnt_idx_s),
        .gnt_any (accept_s)
    );

    // Ready must follow out_ready combinationally so a stall releases in the same cycle.
    assign bus.req_ready = rst_n ? gnt_s : {NREQ{1'b0}};

    // Select the granted requester's back vector
    always_comb begin
        sel_back_s = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_idx_s == TAGW'(i)) begin
                sel_back_s = bus.req_back[i*BACK_W +: BACK_W];
            end else begin
                sel_back_s = sel_back_s;
            end
        end
    end

    // Window reduction of the S1 vector feeding S2
    always_comb begin
        red_s = backor_reduce(s1_back_r);
    end

    // Stage 1: capture the granted vector and its tag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_r    <= 1'b0;
            s1_back_r <= '0;
            s1_tag_r  <= '0;
        end else if (s1_load_s) begin
            s1_v_r <= accept_s;
            if (accept_s) begin
                s1_back_r <= sel_back_s;
                s1_tag_r  <= gnt_idx_s;
            end else begin
                s1_back_r <= s1_back_r;
                s1_tag_r  <= s1_tag_r;
            end
        end else begin
            s1_v_r <= s1_v_r;
        end
    end

    // Stage 2: register reduced bins, any-flag and tag; hold data while stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            out_ret_r   <= '0;
            out_any_r   <= 1'b0;
            out_tag_r   <= '0;
        end else if (s2_load_s) begin
            out_valid_r <= s1_v_r;
            if (s1_v_r) begin
                out_ret_r <= red_s;
                out_any_r <= |red_s;
                out_tag_r <= s1_tag_r;
            end else begin
                out_ret_r <= out_ret_r;
                out_any_r <= out_any_r;
                out_tag_r <= out_tag_r;
            end
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    // Saturating count of accepted requests
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_count_r <= 16'h0000;
        end else if (accept_s && (acc_count_r != 16'hFFFF)) begin
            acc_count_r <= acc_count_r + 16'h0001;
        end else begin
            acc_count_r <= acc_count_r;
        end
    end

    assign bus.out_valid = out_valid_r;
    assign bus.out_ret   = out_ret_r;
    assign bus.out_any   = out_any_r;
    assign bus.out_tag   = out_tag_r;
    assign acc_count     = acc_count_r;

endmodule

// File: tb/tb_backor_scheduler.sv
// tb_backor_scheduler: directed vector table, multi-cycle corner sequences and
// a randomized phase checked against a queue-based reference model.
module tb_backor_scheduler;

    localparam int NREQ = 4;
    localparam int TAGW = 3;

`ifdef BACKOR_WIDE_EN
    localparam int WADJ = 1;
`else
    localparam int WADJ = 0;
`endif

    localparam int LO_T [18] = '{1, 2, 3, 5, 6, 7, 9, 10, 12, 13, 14, 16, 17, 18, 20, 21, 22, 24};
    localparam int HI_T [18] = '{3, 5, 6, 7, 9, 10, 11, 13, 14, 15, 17, 18, 20, 21, 22, 24, 25, 26};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] acc_count;
    int          checks = 0;
    int          errors = 0;

    backor_scheduler_if #(.NREQ(NREQ), .TAGW(TAGW)) bus ();

    backor_scheduler #(.NREQ(NREQ), .TAGW(TAGW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .acc_count (acc_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [27:0] back;
        logic [17:0] ret;
        logic        any;
    } vec_t;

    typedef struct {
        logic [17:0] ret;
        logic [2:0]  tag;
    } exp_t;

    vec_t        tbl [7];
    exp_t        q [$];
    logic [27:0] rb [NREQ];
    logic        rv [NREQ];

    // Reference reduction: each bin is "any bit set inside the window"
    function automatic logic [17:0] ref_reduce(input logic [27:0] b);
        logic [63:0] v;
        logic [63:0] m;
        logic [17:0] r;
        int lo;
        int hi;
        r = '0;
        for (int k = 0; k < 18; k++) begin
            lo = LO_T[k] - WADJ;
            hi = HI_T[k] + WADJ;
            m = (64'd1 << (hi - lo + 1)) - 64'd1;
            v = ({36'd0, b} >> lo) & m;
            r[k] = (v != 64'd0);
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic post_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_backs();
        for (int i = 0; i < NREQ; i++) begin
            bus.req_back[i*28 +: 28] = rb[i];
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.req_valid = '0;
        bus.out_ready = 1'b1;
        post_edge();
        post_edge();
        rst_n = 1'b1;
    endtask

    initial begin
        logic [3:0]  oh;
        logic [17:0] exp_ret;
        logic [3:0]  exp_rdy;
        logic [3:0]  stall_rdy [5];
        int          r;
        int          g;
        int          can;
        logic        popped;

`ifdef BACKOR_WIDE_EN
        tbl[0] = '{28'h000000E, 18'h00007, 1'b1};
        tbl[1] = '{28'h8000000, 18'h20000, 1'b1};
        tbl[2] = '{28'h0000000, 18'h00000, 1'b0};
        tbl[3] = '{28'h0000001, 18'h00001, 1'b1};
        tbl[4] = '{28'h0000100, 18'h00078, 1'b1};
        tbl[5] = '{28'hFFFFFFF, 18'h3FFFF, 1'b1};
        tbl[6] = '{28'h0080000, 18'h07800, 1'b1};
`else
        tbl[0] = '{28'h000000E, 18'h00007, 1'b1};
        tbl[1] = '{28'h8000000, 18'h00000, 1'b0};
        tbl[2] = '{28'h0000000, 18'h00000, 1'b0};
        tbl[3] = '{28'h0000001, 18'h00000, 1'b0};
        tbl[4] = '{28'h0000100, 18'h00030, 1'b1};
        tbl[5] = '{28'hFFFFFFF, 18'h3FFFF, 1'b1};
        tbl[6] = '{28'h0080000, 18'h03000, 1'b1};
`endif
        stall_rdy = '{4'b0010, 4'b0100, 4'b0000, 4'b0000, 4'b0000};

        // ---------------- reset values (requests pending during reset) ----------------
        bus.req_valid = 4'hF;
        bus.req_back  = '0;
        bus.out_ready = 1'b1;
        #2;
        chk("rst_req_ready", bus.req_ready, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_ret", bus.out_ret, 0);
        chk("rst_out_any", bus.out_any, 0);
        chk("rst_out_tag", bus.out_tag, 0);
        chk("rst_acc", acc_count, 0);
        do_reset();

        // ---------------- table vectors, single requester, latency ----------------
        for (int t = 0; t < 7; t++) begin
            post_edge();
            r = t % NREQ;
            oh = 4'b0001 << r;
            for (int i = 0; i < NREQ; i++) rb[i] = 28'h0;
            rb[r] = tbl[t].back;
            drive_backs();
            bus.req_valid = oh;
            #1;
            chk("tbl_ready", bus.req_ready, oh);
            post_edge();
            bus.req_valid = '0;
            #1;
            chk("tbl_not_early", bus.out_valid, 0);
            post_edge();
            #1;
            chk("tbl_valid", bus.out_valid, 1);
            chk("tbl_ret", bus.out_ret, tbl[t].ret);
            chk("tbl_any", bus.out_any, tbl[t].any);
            chk("tbl_tag", bus.out_tag, r);
        end

        // ---------------- all requesters continuously valid ----------------
        do_reset();
        for (int i = 0; i < NREQ; i++) rb[i] = 28'h1111111 * (i + 1);
        drive_backs();
        bus.req_valid = 4'hF;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            #1;
            chk("rot_ready", bus.req_ready, 4'b0001 << (c % NREQ));
            chk("rot_acc", acc_count, c);
            if (c >= 2) begin
                chk("rot_valid", bus.out_valid, 1);
                chk("rot_tag", bus.out_tag, (c - 2) % NREQ);
                chk("rot_ret", bus.out_ret, ref_reduce(rb[(c - 2) % NREQ]));
            end
            post_edge();
        end
        bus.req_valid = '0;

        // ---------------- stall with requesters 1 and 2 pending ----------------
        do_reset();
        for (int i = 0; i < NREQ; i++) rb[i] = 28'h0;
        rb[1] = 28'h0000100;
        rb[2] = 28'h0080000;
        rb[0] = 28'h000000E;
        drive_backs();
        bus.out_ready = 1'b0;
        bus.req_valid = 4'b0110;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("stall_ready", bus.req_ready, stall_rdy[c]);
            if (c >= 2) begin
                chk("stall_valid", bus.out_valid, 1);
                chk("stall_tag", bus.out_tag, 1);
                chk("stall_ret", bus.out_ret, ref_reduce(rb[1]));
            end
            post_edge();
            bus.req_valid = bus.req_valid & ~stall_rdy[c];
        end
        bus.out_ready = 1'b1;
        bus.req_valid = 4'b0001;
        #1;
        chk("release_ready_same_cycle", bus.req_ready, 4'b0001);
        chk("release_tag1", bus.out_tag, 1);
        post_edge();
        bus.req_valid = '0;
        #1;
        chk("release_valid2", bus.out_valid, 1);
        chk("release_tag2", bus.out_tag, 2);
        post_edge();
        #1;
        chk("release_valid0", bus.out_valid, 1);
        chk("release_tag0", bus.out_tag, 0);

        // ---------------- reset while both stages are full ----------------
        do_reset();
        for (int i = 0; i < NREQ; i++) rb[i] = 28'hFFFFFFF;
        drive_backs();
        bus.req_valid = 4'hF;
        bus.out_ready = 1'b0;
        post_edge();
        post_edge();
        post_edge();
        #1;
        chk("pre_rst_valid", bus.out_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", bus.req_ready, 0);
        chk("mid_rst_valid", bus.out_valid, 0);
        chk("mid_rst_ret", bus.out_ret, 0);
        chk("mid_rst_any", bus.out_any, 0);
        chk("mid_rst_tag", bus.out_tag, 0);
        chk("mid_rst_acc", acc_count, 0);
        post_edge();
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        chk("post_rst_first_grant", bus.req_ready, 4'b0001);
        chk("post_rst_no_valid", bus.out_valid, 0);
        post_edge();
        #1;
        chk("post_rst_no_stale", bus.out_valid, 0);
        post_edge();
        #1;
        chk("post_rst_new_valid", bus.out_valid, 1);
        chk("post_rst_new_tag", bus.out_tag, 0);
        bus.req_valid = '0;

        // ---------------- saturating accept counter ----------------
        do_reset();
        force dut.acc_count_r = 16'hFFFE;
        #1;
        release dut.acc_count_r;
        #1;
        chk("sat_preload", acc_count, 16'hFFFE);
        post_edge();
        bus.req_valid = 4'hF;
        for (int c = 0; c < 3; c++) begin
            post_edge();
            #1;
            chk("sat_count", acc_count, 16'hFFFF);
        end
        bus.req_valid = '0;

        // ---------------- randomized traffic against reference model ----------------
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            rv[i] = 1'b0;
            rb[i] = 28'h0;
        end
        q.delete();
        begin
            int ptr_m;
            int acc_m;
            ptr_m = 0;
            acc_m = 0;
            for (int c = 0; c < 3000; c++) begin
                for (int i = 0; i < NREQ; i++) begin
                    if (!rv[i] && ($urandom_range(0, 99) < 40)) begin
                        rv[i] = 1'b1;
                        rb[i] = 28'($urandom);
                    end
                end
                drive_backs();
                for (int i = 0; i < NREQ; i++) bus.req_valid[i] = rv[i];
                bus.out_ready = ($urandom_range(0, 99) < 65);
                #1;
                chk("rnd_acc", acc_count, acc_m);
                popped = 1'b0;
                if (q.size() == 0) begin
                    chk("rnd_empty_valid", bus.out_valid, 0);
                end else if (bus.out_valid && bus.out_ready) begin
                    chk("rnd_ret", bus.out_ret, q[0].ret);
                    chk("rnd_any", bus.out_any, |q[0].ret);
                    chk("rnd_tag", bus.out_tag, q[0].tag);
                    popped = 1'b1;
                end
                can = ((q.size() < 2) || bus.out_ready) ? 1 : 0;
                g = -1;
                for (int off = 0; off < NREQ; off++) begin
                    if (g < 0 && rv[(ptr_m + off) % NREQ]) g = (ptr_m + off) % NREQ;
                end
                if (can == 0) g = -1;
                exp_rdy = (g >= 0) ? (4'b0001 << g) : 4'b0000;
                chk("rnd_ready", bus.req_ready, exp_rdy);
                @(posedge clk);
                if (popped) void'(q.pop_front());
                if (g >= 0) begin
                    exp_ret = ref_reduce(rb[g]);
                    q.push_back('{exp_ret, 3'(g)});
                    rv[g] = 1'b0;
                    ptr_m = (g + 1) % NREQ;
                    if (acc_m < 65535) acc_m = acc_m + 1;
                end
                #1;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
